// File: rtl/nibble_shift_unloader_pkg.sv
// Shared definitions for the nibble shift chain: default geometry, the 3 s tick
// count at 50 MHz and the unloader FSM state encoding.
package nibble_shift_unloader_pkg;

   localparam int unsigned W_DEF     = 4;
   localparam int unsigned DEPTH_DEF = 4;
   localparam int unsigned TICK_3S   = 150000000;
   localparam int unsigned REM_W     = 3;

   typedef enum logic {
      StIdle  = 1'b0,
      StShift = 1'b1
   } state_e;

endpackage

// File: rtl/nibble_shift_unloader_tick_prescaler.sv
// Free-running divider: counts 0..TICK_COUNT-1 while enabled and flags the last
// count as a one-cycle tick. Shared with the serial-in side of the chain.
module nibble_shift_unloader_tick_prescaler #(
   parameter int unsigned TICK_COUNT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_COUNT - 1);

   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_d;
   logic          w_at_last;

   assign w_at_last = (r_count == LAST);

   always_comb begin
      w_count_d = r_count;
      if (clr) begin
         w_count_d = '0;
      end else if (en) begin
         w_count_d = w_at_last ? '0 : r_count + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_d;
      end
   end

   assign tick = en & ~clr & w_at_last;

endmodule

// File: rtl/nibble_shift_unloader.sv
// Parallel-in, serial-out nibble unloader: a synchronised button press captures
// all stages, then one nibble (oldest first) is emitted per prescaler tick.
module nibble_shift_unloader
   import nibble_shift_unloader_pkg::*;
#(
   parameter int unsigned TICK_COUNT = TICK_3S,
   parameter int unsigned W          = W_DEF,
   parameter int unsigned DEPTH      = DEPTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_n,
   input  logic [DEPTH*W-1:0]   par_in,
   output logic [W-1:0]         dout,
   output logic                 dout_valid,
   output logic                 busy,
   output logic [DEPTH*W-1:0]   stages,
   output logic [REM_W-1:0]     remaining
);

   localparam logic [REM_W-1:0] DEPTH_CNT = REM_W'(DEPTH);

   // load_n is asynchronous; r_sync[1] is the first safe sample, r_prev delays it
   logic [1:0]           r_sync;
   logic                 r_prev;
   logic                 w_load_pulse;

   state_e               r_state;
   state_e               w_state_d;
   logic [DEPTH*W-1:0]   r_stages;
   logic [DEPTH*W-1:0]   w_stages_d;
   logic [W-1:0]         r_dout;
   logic [W-1:0]         w_dout_d;
   logic                 r_dout_valid;
   logic                 w_dout_valid_d;
   logic                 r_busy;
   logic                 w_busy_d;
   logic [REM_W-1:0]     r_remaining;
   logic [REM_W-1:0]     w_remaining_d;

   logic                 w_tick;
   logic                 w_pre_en;
   logic                 w_pre_clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= 2'b11;
         r_prev <= 1'b1;
      end else begin
         r_sync <= {r_sync[0], load_n};
         r_prev <= r_sync[1];
      end
   end

   assign w_load_pulse = r_prev & ~r_sync[1];

   assign w_pre_en  = (r_state == StShift);
   assign w_pre_clr = (r_state == StIdle);

   nibble_shift_unloader_tick_prescaler #(
      .TICK_COUNT (TICK_COUNT)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_pre_en),
      .clr   (w_pre_clr),
      .tick  (w_tick)
   );

   // Presses during SHIFT fall through: only IDLE looks at w_load_pulse, so a
   // press coinciding with the final tick is dropped.
   always_comb begin
      w_state_d      = r_state;
      w_stages_d     = r_stages;
      w_dout_d       = r_dout;
      w_dout_valid_d = 1'b0;
      w_busy_d       = r_busy;
      w_remaining_d  = r_remaining;
      unique case (r_state)
         StIdle: begin
            if (w_load_pulse) begin
               w_stages_d    = par_in;
               w_remaining_d = DEPTH_CNT;
               w_busy_d      = 1'b1;
               w_state_d     = StShift;
            end
         end
         StShift: begin
            if (w_tick) begin
               w_dout_d       = r_stages[DEPTH*W-1 -: W];
               w_dout_valid_d = 1'b1;
               w_stages_d     = r_stages << W;
               if (r_remaining <= REM_W'(1)) begin
                  w_remaining_d = '0;
                  w_busy_d      = 1'b0;
                  w_state_d     = StIdle;
               end else begin
                  w_remaining_d = r_remaining - REM_W'(1);
               end
            end
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= StIdle;
         r_stages     <= '0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_busy       <= 1'b0;
         r_remaining  <= '0;
      end else begin
         r_state      <= w_state_d;
         r_stages     <= w_stages_d;
         r_dout       <= w_dout_d;
         r_dout_valid <= w_dout_valid_d;
         r_busy       <= w_busy_d;
         r_remaining  <= w_remaining_d;
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign busy       = r_busy;
   assign stages     = r_stages;
   assign remaining  = r_remaining;

endmodule

// File: tb/tb_nibble_shift_unloader.sv
// Scoreboard bench for nibble_shift_unloader with TICK_COUNT=4, W=4, DEPTH=4.
`timescale 1ns/1ps
module tb_nibble_shift_unloader;

   localparam int unsigned TC = 4;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        load_n = 1'b1;
   logic [15:0] par_in = 16'h0000;
   logic [3:0]  dout;
   logic        dout_valid;
   logic        busy;
   logic [15:0] stages;
   logic [2:0]  remaining;

   nibble_shift_unloader #(
      .TICK_COUNT (TC),
      .W          (4),
      .DEPTH      (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_n     (load_n),
      .par_in     (par_in),
      .dout       (dout),
      .dout_valid (dout_valid),
      .busy       (busy),
      .stages     (stages),
      .remaining  (remaining)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [3:0] nib;
      int         at;
      bit         last;
   } exp_t;

   exp_t sb[$];
   int   n_run  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (dout_valid === 1'b1) begin
            if (sb.size() == 0) begin
               n_run++;
               n_fail++;
               $display("FAIL unexpected_pulse: got dout=0x%0h at cycle %0d, expected no pulse",
                        dout, cyc);
            end else begin
               e = sb.pop_front();
               check("dout", {28'd0, dout}, {28'd0, e.nib});
               check("pulse_cycle", cyc, e.at);
               check("busy_with_pulse", {31'd0, busy}, e.last ? 32'd0 : 32'd1);
            end
         end
      end
   endtask

   task automatic wait_capture(output int c);
      bit seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (busy === 1'b1) seen = 1;
      end
      c = cyc;
      if (!seen) check("capture_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle(input int max_cyc);
      bit seen = 0;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         @(negedge clk);
         if (busy === 1'b0) seen = 1;
      end
      if (!seen) check("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic push_seq(input logic [15:0] v, input int c);
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         e.nib  = v[15-4*k -: 4];
         e.at   = c + int'(TC) * (k + 1);
         e.last = (k == 3);
         sb.push_back(e);
      end
   endtask

   task automatic run_all();
      int c;
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_dout", {28'd0, dout}, 32'd0);
      check("rst_valid", {31'd0, dout_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_stages", {16'd0, stages}, 32'd0);
      check("rst_remaining", {29'd0, remaining}, 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_busy", {31'd0, busy}, 32'd0);

      // Basic unload of A5C3
      par_in = 16'hA5C3;
      load_n = 1'b0;
      wait_capture(c);
      load_n = 1'b1;
      check("cap_stages", {16'd0, stages}, 32'h0000_A5C3);
      check("cap_remaining", {29'd0, remaining}, 32'd4);
      check("cap_dout_held", {28'd0, dout}, 32'd0);
      push_seq(16'hA5C3, c);
      repeat (5) @(negedge clk);
      check("mid_remaining", {29'd0, remaining}, 32'd3);
      check("mid_stages", {16'd0, stages}, 32'h0000_5C30);
      wait_idle(30);
      check("done_cycle", cyc, c + 16);
      check("done_stages", {16'd0, stages}, 32'd0);
      check("done_remaining", {29'd0, remaining}, 32'd0);
      check("done_dout_held", {28'd0, dout}, 32'h3);

      // Long hold: one capture only
      par_in = 16'h9876;
      load_n = 1'b0;
      wait_capture(c);
      push_seq(16'h9876, c);
      repeat (20) @(negedge clk);
      load_n = 1'b1;
      repeat (10) @(negedge clk);
      check("hold_busy", {31'd0, busy}, 32'd0);
      check("hold_sb_empty", sb.size(), 32'd0);

      // Second press during unload is ignored
      par_in = 16'h1234;
      load_n = 1'b0;
      wait_capture(c);
      load_n = 1'b1;
      push_seq(16'h1234, c);
      par_in = 16'hFFFF;
      repeat (5) @(negedge clk);
      load_n = 1'b0;
      repeat (3) @(negedge clk);
      load_n = 1'b1;
      check("repress_remaining", {29'd0, remaining}, 32'd2);
      wait_idle(30);
      repeat (10) @(negedge clk);
      check("repress_busy", {31'd0, busy}, 32'd0);

      // Press lands on the final tick: dropped
      par_in = 16'h7E81;
      load_n = 1'b0;
      wait_capture(c);
      load_n = 1'b1;
      push_seq(16'h7E81, c);
      repeat (13) @(negedge clk);
      load_n = 1'b0;
      repeat (4) @(negedge clk);
      load_n = 1'b1;
      check("final_busy", {31'd0, busy}, 32'd0);
      check("final_remaining", {29'd0, remaining}, 32'd0);
      repeat (10) @(negedge clk);
      check("final_no_recapture", {31'd0, busy}, 32'd0);

      // Glitch between edges: never sampled
      @(negedge clk);
      #1 load_n = 1'b0;
      #2 load_n = 1'b1;
      repeat (8) @(negedge clk);
      check("glitch_busy", {31'd0, busy}, 32'd0);

      // Short low across one rising edge: sampled once
      par_in = 16'hF0E1;
      @(negedge clk);
      #3 load_n = 1'b0;
      @(posedge clk);
      #2 load_n = 1'b1;
      wait_capture(c);
      push_seq(16'hF0E1, c);
      wait_idle(30);

      // Reset mid-unload
      par_in = 16'h5A5A;
      load_n = 1'b0;
      wait_capture(c);
      load_n = 1'b1;
      push_seq(16'h5A5A, c);
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_dout", {28'd0, dout}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_stages", {16'd0, stages}, 32'd0);
      check("mid_rst_remaining", {29'd0, remaining}, 32'd0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      check("post_rst_valid", {31'd0, dout_valid}, 32'd0);

      // Normal operation resumes after reset
      par_in = 16'h0C0D;
      load_n = 1'b0;
      wait_capture(c);
      load_n = 1'b1;
      push_seq(16'h0C0D, c);
      wait_idle(30);
      repeat (5) @(negedge clk);
      check("sb_drained", sb.size(), 32'd0);
   endtask

   initial begin
      fork
         monitor();
      join_none
      run_all();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
